// File: rtl/kernel_b_kb_vsum_pkg.sv
// Shared definitions for the kb vector-sum reduction stage and later fold nodes.
//   state_t        : output-side state (ACC = no pending sum, HOLD = sum waiting on oready)
//   *_DEFAULT      : default widths and block length
//   last_count()   : terminal element index for a block of ntot elements
package kernel_b_kb_vsum_pkg;

  localparam int unsigned STREAMW_DEFAULT = 32;
  localparam int unsigned NTOT_DEFAULT    = 1024;
  localparam int unsigned CNTW_DEFAULT    = 16;

  // Terminal count for the default block length.
  localparam int unsigned LAST_DEFAULT    = NTOT_DEFAULT - 1;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int unsigned last_count(input int unsigned ntot);
    return ntot - 1;
  endfunction

endpackage

// File: rtl/kernel_b_kb_vsum_blkcnt.sv
// Block element counter for fold nodes.
//   clk, rst : clock, synchronous active-high reset
//   inc      : count one element this cycle
//   tc       : registered flag, high while the count equals LAST
// The count wraps to zero when incremented at LAST.
module kernel_b_kb_blkcnt #(
  parameter int unsigned CNTW = 16,
  parameter int unsigned LAST = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output logic tc
);

  localparam logic [CNTW-1:0] LAST_C = CNTW'(LAST);

  logic [CNTW-1:0] cnt;

  // tc is carried as its own register so the consumer sees a flop output
  // instead of a CNTW-bit comparator; it is recomputed from the next count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      tc  <= (LAST_C == '0);
    end else if (inc) begin
      if (tc) begin
        cnt <= '0;
        tc  <= (LAST_C == '0);
      end else begin
        cnt <= cnt + 1'b1;
        tc  <= ((cnt + 1'b1) == LAST_C);
      end
    end
  end

endmodule

// File: rtl/kernel_b_kb_vsum.sv
// Reduction stage for the kb vector-add node: folds every NTOT consecutive
// input words into one modulo-2^STREAMW sum.
//   clk, rst : clock, synchronous active-high reset
//   ivalid   : in1_s0 valid
//   iready   : word can be taken this cycle (combinational from oready)
//   in1_s0   : input element
//   ovalid   : registered, out1_s0 holds a completed sum
//   oready   : downstream takes out1_s0 this cycle
//   out1_s0  : registered block sum
module kernel_b_kb_vsum
  import kernel_b_kb_vsum_pkg::*;
#(
  parameter int unsigned STREAMW = STREAMW_DEFAULT,
  parameter int unsigned NTOT    = NTOT_DEFAULT,
  parameter int unsigned CNTW    = CNTW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ivalid,
  output logic               iready,
  input  logic [STREAMW-1:0] in1_s0,
  output logic               ovalid,
  input  logic               oready,
  output logic [STREAMW-1:0] out1_s0
);

  localparam int unsigned LAST = last_count(NTOT);

  if (NTOT < 1 || 64'(NTOT) > (64'(1) << CNTW)) begin : g_bad_params
    $error("kernel_b_kb_vsum: NTOT must satisfy 1 <= NTOT <= 2**CNTW");
  end

  state_t             state;
  logic [STREAMW-1:0] acc;
  logic [STREAMW-1:0] sum;
  logic               accept;
  logic               drain;
  logic               last;

  always_comb begin
    iready = (state == ACC) | oready;
    accept = ivalid & iready;
    drain  = (state == HOLD) & oready;
    sum    = acc + in1_s0;
  end

  kernel_b_kb_blkcnt #(
    .CNTW (CNTW),
    .LAST (LAST)
  ) u_blkcnt (
    .clk (clk),
    .rst (rst),
    .inc (accept),
    .tc  (last)
  );

  // The last-word accept is written after the drain so that a simultaneous
  // drain and reload leaves the stage in HOLD with the new sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACC;
      ovalid  <= 1'b0;
      out1_s0 <= '0;
      acc     <= '0;
    end else begin
      if (drain) begin
        state  <= ACC;
        ovalid <= 1'b0;
      end
      if (accept) begin
        if (last) begin
          out1_s0 <= sum;
          ovalid  <= 1'b1;
          state   <= HOLD;
          acc     <= '0;
        end else begin
          acc <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_kernel_b_kb_vsum.sv
module tb_kernel_b_kb_vsum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ivalid = 1'b0;
  logic        oready = 1'b0;
  logic [31:0] din = '0;

  logic [2:0]  iready_s;
  logic [2:0]  ovalid_s;
  logic [31:0] out4, out1;
  logic [7:0]  out8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // k=0: NTOT=4 W=32, k=1: NTOT=1 W=32, k=2: NTOT=4 W=8
  kernel_b_kb_vsum #(.STREAMW(32), .NTOT(4), .CNTW(16)) u4 (
    .clk(clk), .rst(rst), .ivalid(ivalid), .iready(iready_s[0]),
    .in1_s0(din), .ovalid(ovalid_s[0]), .oready(oready), .out1_s0(out4));

  kernel_b_kb_vsum #(.STREAMW(32), .NTOT(1), .CNTW(16)) u1 (
    .clk(clk), .rst(rst), .ivalid(ivalid), .iready(iready_s[1]),
    .in1_s0(din), .ovalid(ovalid_s[1]), .oready(oready), .out1_s0(out1));

  kernel_b_kb_vsum #(.STREAMW(8), .NTOT(4), .CNTW(16)) u8 (
    .clk(clk), .rst(rst), .ivalid(ivalid), .iready(iready_s[2]),
    .in1_s0(din[7:0]), .ovalid(ovalid_s[2]), .oready(oready), .out1_s0(out8));

  // Behavioural model: each instance keeps the words of the current block,
  // and a finished block's sum is recomputed from the stored words.
  int unsigned ntot [3] = '{4, 1, 4};
  logic [31:0] mask [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};
  logic [31:0] blkw [3][4];
  int unsigned m_n   [3];
  logic        m_pend[3];
  logic [31:0] m_out [3];
  logic        m_on = 1'b0;

  function automatic logic [31:0] dut_out(input int k);
    if (k == 0) return out4;
    else if (k == 1) return out1;
    else return {24'h0, out8};
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d act=%0d exp=%0d t=%0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] s;
    logic        take;
    for (int k = 0; k < 3; k++) begin
      if (m_on) begin
        chk("iready", k, {31'h0, iready_s[k]}, {31'h0, (!m_pend[k]) | oready});
        chk("ovalid", k, {31'h0, ovalid_s[k]}, {31'h0, m_pend[k]});
        chk("out1_s0", k, dut_out(k), m_out[k]);
      end
      if (rst) begin
        m_pend[k] = 1'b0;
        m_out[k]  = '0;
        m_n[k]    = 0;
      end else begin
        take = ivalid && (!m_pend[k] || oready);
        if (m_pend[k] && oready) m_pend[k] = 1'b0;
        if (take) begin
          blkw[k][m_n[k]] = din & mask[k];
          m_n[k]++;
          if (m_n[k] == ntot[k]) begin
            s = '0;
            for (int unsigned i = 0; i < ntot[k]; i++) s = (s + blkw[k][i]) & mask[k];
            m_out[k]  = s;
            m_pend[k] = 1'b1;
            m_n[k]    = 0;
          end
        end
      end
    end
    if (rst) m_on = 1'b1;
  endtask

  // One cycle: drive inputs just after the edge, check/advance the model at the falling edge.
  task automatic cyc(input logic v, input logic [31:0] d, input logic o, input logic r);
    @(posedge clk);
    #1;
    ivalid = v; din = d; oready = o; rst = r;
    @(negedge clk);
    model_step();
  endtask

  initial begin
    // reset held three cycles, idle inputs
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1);
      if (i > 0) begin
        chk("rst_ovalid", 0, {31'h0, ovalid_s[0]}, 32'd0);
        chk("rst_out", 0, out4, 32'd0);
        chk("rst_iready", 0, {31'h0, iready_s[0]}, 32'd1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      chk("idle_ovalid", 0, {31'h0, ovalid_s[0]}, 32'd0);
      chk("idle_iready", 0, {31'h0, iready_s[0]}, 32'd1);
    end

    // 1,2,3,4 -> 10 for exactly one cycle
    for (int i = 1; i <= 4; i++) cyc(1, i, 1, 0);
    cyc(0, 0, 1, 0);
    chk("sum10_valid", 0, {31'h0, ovalid_s[0]}, 32'd1);
    chk("sum10", 0, out4, 32'd10);
    cyc(0, 0, 1, 0);
    chk("sum10_drop", 0, {31'h0, ovalid_s[0]}, 32'd0);

    // 200,100,50,10 -> 104 at 8 bits, 360 at 32 bits
    cyc(1, 200, 1, 0); cyc(1, 100, 1, 0); cyc(1, 50, 1, 0); cyc(1, 10, 1, 0);
    cyc(0, 0, 1, 0);
    chk("wrap8", 2, {24'h0, out8}, 32'd104);
    chk("nowrap32", 0, out4, 32'd360);

    // backpressure after a result
    for (int i = 1; i <= 4; i++) cyc(1, i, 1, 0);
    cyc(1, 5, 0, 0);
    chk("hold_out", 0, out4, 32'd10);
    chk("hold_valid", 0, {31'h0, ovalid_s[0]}, 32'd1);
    chk("hold_iready", 0, {31'h0, iready_s[0]}, 32'd0);
    cyc(1, 5, 0, 0);
    chk("hold_out2", 0, out4, 32'd10);
    cyc(1, 5, 1, 0);
    chk("drain_iready", 0, {31'h0, iready_s[0]}, 32'd1);
    cyc(1, 5, 1, 0);
    chk("drain_drop", 0, {31'h0, ovalid_s[0]}, 32'd0);
    cyc(1, 5, 1, 0);
    cyc(1, 5, 1, 0);
    cyc(0, 0, 1, 0);
    chk("sum20", 0, out4, 32'd20);
    chk("sum20_valid", 0, {31'h0, ovalid_s[0]}, 32'd1);

    // NTOT=1 full throughput
    cyc(1, 7, 1, 0);
    cyc(1, 8, 1, 0);
    chk("n1_7", 1, out1, 32'd7);
    cyc(1, 9, 1, 0);
    chk("n1_8", 1, out1, 32'd8);
    chk("n1_valid", 1, {31'h0, ovalid_s[1]}, 32'd1);
    cyc(0, 0, 1, 0);
    chk("n1_9", 1, out1, 32'd9);
    chk("n1_valid2", 1, {31'h0, ovalid_s[1]}, 32'd1);

    // reset mid-block discards the partial sum
    cyc(0, 0, 1, 1);
    cyc(1, 3, 1, 0); cyc(1, 3, 1, 0);
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0);
    cyc(0, 0, 1, 0);
    chk("rst_discard", 0, out4, 32'd4);
    chk("rst_discard_v", 0, {31'h0, ovalid_s[0]}, 32'd1);

    // randomized traffic with backpressure and occasional reset
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 299) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kernel_b_kb_vsum.md
Name: kernel_B_kb_vsum

Overview:
Downstream reduction stage for the kb vector-add node. It consumes the element-wise sum stream, one STREAMW word per handshake, and accumulates NTOT consecutive elements. It emits one registered scalar sum per block of NTOT elements to the next stage or the output stream writer. It uses the same ivalid/iready/ovalid/oready streaming handshake as the other leaf map nodes.

Parameters:
STREAMW, 32, width of the input word, accumulator and output word.
NTOT, 1024, number of input elements folded into each output sum; must be >= 1.
CNTW, 16, element counter width; NTOT <= 2^CNTW is required; elaboration fails otherwise.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
ivalid  input  1  upstream word on in1_s0 is valid.
iready  output  1  block can accept a word this cycle (combinational).
in1_s0  input  STREAMW  input element (the vout stream).
ovalid  output  1  registered; out1_s0 holds a completed sum.
oready  input  1  downstream accepts out1_s0 this cycle.
out1_s0  output  STREAMW  registered block sum.

Behaviour:
- Reset (rst=1 at a clock edge):
  - acc=0, cnt=0, state=ACC, ovalid=0, out1_s0=0.
  - Reset mid-block discards the partial sum and any pending output.
- Input transfer: a word is accepted in a cycle with ivalid & iready.
- States:
  - ACC: no pending output.
  - HOLD: ovalid=1, output awaiting oready.
- iready = (state==ACC) | oready.
  - This is combinational, with no register from oready to iready.
  - In HOLD, a word can be accepted in the same cycle the pending result is taken.
- Accepted word, not last (cnt != NTOT-1): acc <= acc + in1_s0 (mod 2^STREAMW, carry dropped); cnt <= cnt+1.
- Accepted word, last (cnt == NTOT-1):
  - out1_s0 <= acc + in1_s0.
  - ovalid <= 1, state <= HOLD.
  - acc <= 0, cnt <= 0.
- Latency: ovalid rises on the edge after the last element's transfer cycle (1 cycle).
- HOLD with oready=1 and no last-word accept: ovalid <= 0, state <= ACC. out1_s0 keeps its value.
- HOLD with oready=0: out1_s0, ovalid, acc and cnt are all frozen; iready=0.
- Simultaneous output transfer and last-word accept (HOLD, oready=1, last word):
  - The new sum loads out1_s0, ovalid stays 1, state stays HOLD.
  - This is the only case when NTOT=1; it gives full throughput of one sum per cycle.
- ivalid=0 cycles: no state change, apart from the output being drained.
- out1_s0 changes only on a last-word accept or reset. It is stable whenever ovalid=1 and oready=0.
- Overflow: no saturation, no flag; modulo wrap only.
- No combinational path from in1_s0 to out1_s0.

Decomposition:
- Shared package holds:
  - the state encoding (ACC=1'b0, HOLD=1'b1);
  - the STREAMW default;
  - a localparam for the last-count compare (NTOT-1).
- One sub-module, kernel_B_kb_blkcnt: a CNTW-bit counter with an increment enable and a registered terminal-count flag (cnt==NTOT-1), cleared on wrap. It is reused by later fold nodes.
- The accumulator and the FSM stay in the top module.

Test Plan:
- NTOT=4, rst held 3 cycles, then released with ivalid=0 -> ovalid=0, out1_s0=0, iready=1 throughout.
- NTOT=4, oready=1, inputs 1,2,3,4 on consecutive cycles -> ovalid=1 with out1_s0=10 one cycle after the 4th transfer, for exactly 1 cycle.
- NTOT=4, STREAMW=8, inputs 200,100,50,10 -> out1_s0=104 (360 mod 256), no other flag.
- NTOT=4, oready=0 after the result:
  - Result 10 held, ovalid=1, iready=0, and a 5th input presented with ivalid=1 is not accepted.
  - Then oready=1 -> the word is accepted in that cycle and ovalid drops next cycle.
  - The next block 5,5,5,5 yields 20.
- NTOT=1, ivalid=oready=1, inputs 7,8,9 -> out1_s0 shows 7,8,9 on successive cycles with ovalid continuously 1.
- NTOT=4, rst asserted after 2 of 4 inputs (3,3), then 1,1,1,1 -> out1_s0=4 (the partial sum is discarded).
